// File: rtl/bsg_downstream_deser_fifo.sv
// Downstream receive stage: packs IO_W-bit beats into CORE_W-bit words, queues
// up to DEPTH words for the core, and returns one credit token per word popped.
module bsg_downstream_deser_fifo #(
    parameter int IO_W  = 8,
    parameter int BEATS = 4,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_valid_in,
    input  logic [IO_W-1:0]               io_data_in,
    output logic                          io_token_out,
    output logic                          core_valid_out,
    output logic [IO_W*BEATS-1:0]         core_data_out,
    input  logic                          core_ready,
    output logic                          full,
    output logic [$clog2(DEPTH):0]        count,
    output logic [$clog2(BEATS)-1:0]      beat_cnt,
    output logic                          overflow_err
);

    localparam int CORE_W = IO_W * BEATS;
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = $clog2(BEATS);

    logic [CORE_W-1:0] asm_q, asm_d;
    logic [BW-1:0]     beatCnt_q, beatCnt_d;
    logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic              token_q, token_d;
    logic              overflow_q, overflow_d;
    logic [CORE_W-1:0] mem_q [DEPTH];

    logic empty, isFull, lastBeat, pop, push;

    assign empty    = (wptr_q == rptr_q);
    assign isFull   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign lastBeat = io_valid_in && (beatCnt_q == BW'(BEATS - 1));
    assign pop      = !empty && core_ready;
    // A full FIFO still accepts the word if the head leaves on the same edge.
    assign push     = !rst && lastBeat && (!isFull || pop);

    always_comb begin
        asm_d      = asm_q;
        beatCnt_d  = beatCnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        token_d    = pop;
        if (io_valid_in) begin
            asm_d[int'(beatCnt_q) * IO_W +: IO_W] = io_data_in;
            beatCnt_d = lastBeat ? '0 : beatCnt_q + BW'(1);
        end
        if (push) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end else if (lastBeat) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= '0;
            beatCnt_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            token_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            beatCnt_q  <= beatCnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            token_q    <= token_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the output is gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= asm_d;
        end
    end

    assign core_valid_out = !empty;
    assign core_data_out  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign io_token_out   = token_q;
    assign full           = isFull;
    assign count          = wptr_q - rptr_q;
    assign beat_cnt       = beatCnt_q;
    assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_bsg_downstream_deser_fifo.sv
// Directed self-checking bench for bsg_downstream_deser_fifo (IO_W=8, BEATS=4, DEPTH=4).
module tb_bsg_downstream_deser_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_valid_in;
    logic [7:0]  io_data_in;
    logic        io_token_out;
    logic        core_valid_out;
    logic [31:0] core_data_out;
    logic        core_ready;
    logic        full;
    logic [2:0]  count;
    logic [1:0]  beat_cnt;
    logic        overflow_err;

    int compared   = 0;
    int mismatched = 0;
    int rxCount    = 0;
    int tokenCount = 0;
    int fullSeen   = 0;

    bsg_downstream_deser_fifo #(.IO_W(8), .BEATS(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .io_valid_in(io_valid_in), .io_data_in(io_data_in),
        .io_token_out(io_token_out),
        .core_valid_out(core_valid_out), .core_data_out(core_data_out),
        .core_ready(core_ready),
        .full(full), .count(count), .beat_cnt(beat_cnt),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordOf(input int i);
        return 32'h04030201 + 32'h10101010 * i;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        io_valid_in = 1'b1;
        io_data_in  = d;
        tick();
        io_valid_in = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int b = 0; b < 4; b++) applyStimulus(w[8*b +: 8]);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic monitor();
        if (core_valid_out) begin
            checkOutput("wrap_order", 64'(core_data_out), 64'(wordOf(rxCount)));
            rxCount++;
        end
        if (io_token_out) tokenCount++;
        if (full) fullSeen++;
    endtask

    initial begin
        rst = 1'b1; io_valid_in = 1'b0; io_data_in = '0; core_ready = 1'b0;
        tick();
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_beat", 64'(beat_cnt), 64'd0);
        checkOutput("rst_valid", 64'(core_valid_out), 64'd0);
        checkOutput("rst_data", 64'(core_data_out), 64'd0);
        checkOutput("rst_token", 64'(io_token_out), 64'd0);
        checkOutput("rst_full", 64'(full), 64'd0);
        checkOutput("rst_ovf", 64'(overflow_err), 64'd0);
        rst = 1'b0;

        // Single word with the core always ready
        core_ready = 1'b1;
        applyStimulus(8'h11);
        checkOutput("single_beat1", 64'(beat_cnt), 64'd1);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        checkOutput("single_novalid", 64'(core_valid_out), 64'd0);
        applyStimulus(8'h44);
        checkOutput("single_valid", 64'(core_valid_out), 64'd1);
        checkOutput("single_data", 64'(core_data_out), 64'h44332211);
        checkOutput("single_count1", 64'(count), 64'd1);
        checkOutput("single_beat0", 64'(beat_cnt), 64'd0);
        checkOutput("single_tok0", 64'(io_token_out), 64'd0);
        tick();
        checkOutput("single_tok1", 64'(io_token_out), 64'd1);
        checkOutput("single_count0", 64'(count), 64'd0);
        checkOutput("single_empty", 64'(core_valid_out), 64'd0);
        tick();
        checkOutput("single_tok_end", 64'(io_token_out), 64'd0);

        // Backpressure fill then overflow
        core_ready = 1'b0;
        for (int i = 0; i < 4; i++) sendWord(wordOf(i));
        checkOutput("bp_full", 64'(full), 64'd1);
        checkOutput("bp_count", 64'(count), 64'd4);
        checkOutput("bp_head", 64'(core_data_out), 64'(wordOf(0)));
        tick();
        tick();
        checkOutput("bp_head_stable", 64'(core_data_out), 64'(wordOf(0)));
        checkOutput("bp_ovf_pre", 64'(overflow_err), 64'd0);
        sendWord(32'hDEADBEEF);
        checkOutput("bp_ovf", 64'(overflow_err), 64'd1);
        checkOutput("bp_count_ovf", 64'(count), 64'd4);
        checkOutput("bp_beat_wrap", 64'(beat_cnt), 64'd0);
        checkOutput("bp_head_ovf", 64'(core_data_out), 64'(wordOf(0)));
        core_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_drain", 64'(core_data_out), 64'(wordOf(i)));
            tick();
        end
        core_ready = 1'b0;
        checkOutput("bp_drained", 64'(count), 64'd0);
        checkOutput("bp_ovf_sticky", 64'(overflow_err), 64'd1);
        doReset();
        checkOutput("bp_ovf_cleared", 64'(overflow_err), 64'd0);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) sendWord(wordOf(i));
        for (int b = 0; b < 3; b++) applyStimulus(wordOf(4)[8*b +: 8]);
        core_ready = 1'b1;
        applyStimulus(wordOf(4)[31:24]);
        core_ready = 1'b0;
        checkOutput("pp_ovf", 64'(overflow_err), 64'd0);
        checkOutput("pp_count", 64'(count), 64'd4);
        checkOutput("pp_full", 64'(full), 64'd1);
        checkOutput("pp_token", 64'(io_token_out), 64'd1);
        checkOutput("pp_head", 64'(core_data_out), 64'(wordOf(1)));
        core_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checkOutput("pp_drain", 64'(core_data_out), 64'(wordOf(i)));
            tick();
        end
        core_ready = 1'b0;
        checkOutput("pp_empty", 64'(count), 64'd0);

        // Gapped beats: valid pattern 1,0,0,1,1,0,1
        applyStimulus(8'hA1);
        tick();
        tick();
        checkOutput("gap_beat_hold", 64'(beat_cnt), 64'd1);
        applyStimulus(8'hB2);
        applyStimulus(8'hC3);
        tick();
        checkOutput("gap_nopush", 64'(count), 64'd0);
        applyStimulus(8'hD4);
        checkOutput("gap_count", 64'(count), 64'd1);
        checkOutput("gap_beat", 64'(beat_cnt), 64'd0);
        checkOutput("gap_data", 64'(core_data_out), 64'hD4C3B2A1);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        checkOutput("gap_popped", 64'(count), 64'd0);

        // Reset in the middle of a word with two words stored
        sendWord(wordOf(5));
        sendWord(wordOf(6));
        applyStimulus(8'hEE);
        applyStimulus(8'hFF);
        checkOutput("mid_beat", 64'(beat_cnt), 64'd2);
        checkOutput("mid_count", 64'(count), 64'd2);
        rst = 1'b1;
        applyStimulus(8'h99);
        rst = 1'b0;
        checkOutput("mid_rst_count", 64'(count), 64'd0);
        checkOutput("mid_rst_beat", 64'(beat_cnt), 64'd0);
        checkOutput("mid_rst_valid", 64'(core_valid_out), 64'd0);
        checkOutput("mid_rst_data", 64'(core_data_out), 64'd0);
        applyStimulus(8'h55);
        applyStimulus(8'h66);
        applyStimulus(8'h77);
        applyStimulus(8'h88);
        checkOutput("mid_word", 64'(core_data_out), 64'h88776655);
        checkOutput("mid_word_count", 64'(count), 64'd1);
        core_ready = 1'b1;
        tick();

        // Pointer wrap: ten words streamed with the core always ready
        rxCount = 0;
        tokenCount = 0;
        fullSeen = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(wordOf(i)[8*b +: 8]);
                monitor();
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            monitor();
        end
        checkOutput("wrap_words", 64'(rxCount), 64'd10);
        checkOutput("wrap_tokens", 64'(tokenCount), 64'd10);
        checkOutput("wrap_full", 64'(fullSeen), 64'd0);
        checkOutput("wrap_ovf", 64'(overflow_err), 64'd0);
        checkOutput("wrap_count", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
